// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge driver: BCD duty to 1000-tick PWM, dead-time on reversal, immediate brake/coast.
// Optional build macro SOFT_START_EN adds a per-period duty ramp when a channel starts moving.
`timescale 1ns/1ps
module motor_pwm_driver #(
  parameter int CLK_DIV      = 50,
  parameter int DEAD_PERIODS = 20,
  parameter int RAMP_STEP    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dir_a,
  input  logic [1:0]  dir_b,
  input  logic [11:0] duty_a,
  input  logic [11:0] duty_b,
  output logic        in1_a,
  output logic        in2_a,
  output logic        en_a,
  output logic        in1_b,
  output logic        in2_b,
  output logic        en_b,
  output logic        period_start,
  output logic        dead_a,
  output logic        dead_b
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

  typedef enum logic [2:0] {ST_COAST, ST_FWD, ST_REV, ST_BRAKE, ST_DEAD} state_t;

  if (CLK_DIV < 1 || DEAD_PERIODS < 0 || RAMP_STEP < 1) begin : g_param_check
    $error("motor_pwm_driver: invalid parameter value");
  end

  function automatic logic [9:0] bcd_to_bin(input logic [11:0] bcd);
    logic [3:0] h, t, u;
    h = (bcd[11:8] > 4'd9) ? 4'd9 : bcd[11:8];
    t = (bcd[7:4]  > 4'd9) ? 4'd9 : bcd[7:4];
    u = (bcd[3:0]  > 4'd9) ? 4'd9 : bcd[3:0];
    return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(u);
  endfunction

  // Input stage; idle value is coast so reset does not look like a brake command.
  logic [1:0][1:0]  dir_q;
  logic [1:0][11:0] duty_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= {2{2'b11}};
      duty_q <= '0;
    end else begin
      dir_q  <= {dir_b, dir_a};
      duty_q <= {duty_b, duty_a};
    end
  end

  logic [PW-1:0] presc_q;
  logic [9:0]    cnt_q, cnt_d;
  logic          tick, wrap, period_start_q;

  assign tick = (presc_q == PW'(CLK_DIV - 1));
  assign wrap = tick && (cnt_q == 10'd999);

  always_comb begin
    cnt_d = cnt_q;
    if (wrap)      cnt_d = '0;
    else if (tick) cnt_d = cnt_q + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= tick ? '0 : presc_q + PW'(1);
      cnt_q          <= cnt_d;
      period_start_q <= wrap;
    end
  end
  assign period_start = period_start_q;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t        st_q, st_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [9:0]    lat_d, lat_q, eff;
    logic          run, cmd_fwd, in1_q, in2_q, en_q, dead_flag_q;

    assign cmd_fwd = (dir_q[c] == 2'b10);

    always_comb begin
      st_d   = st_q;
      dead_d = dead_q;
      lat_d  = wrap ? bcd_to_bin(duty_q[c]) : lat_q;
      case (dir_q[c])
        2'b00: begin st_d = ST_BRAKE; dead_d = '0; end
        2'b11: begin st_d = ST_COAST; dead_d = '0; end
        default: begin
          if (wrap) begin
            case (st_q)
              ST_COAST, ST_BRAKE: st_d = cmd_fwd ? ST_FWD : ST_REV;
              ST_FWD, ST_REV: begin
                if (cmd_fwd != (st_q == ST_FWD)) begin
                  if (DEAD_PERIODS == 0) begin
                    st_d = cmd_fwd ? ST_FWD : ST_REV;
                  end else begin
                    st_d   = ST_DEAD;
                    dead_d = DW'(DEAD_PERIODS);
                  end
                end
              end
              // Last dead period ends here; exit to whatever is commanded now.
              ST_DEAD: begin
                if (dead_q <= DW'(1)) begin
                  st_d   = cmd_fwd ? ST_FWD : ST_REV;
                  dead_d = '0;
                end else begin
                  dead_d = dead_q - DW'(1);
                end
              end
              default: st_d = ST_COAST;
            endcase
          end
        end
      endcase
    end

    assign run = (st_d == ST_FWD) || (st_d == ST_REV);

`ifdef SOFT_START_EN
    logic [9:0]  ramp_q, ramp_d;
    logic [10:0] ramp_sum;
    always_comb begin
      ramp_sum = {1'b0, ramp_q} + 11'(RAMP_STEP);
      ramp_d   = ramp_q;
      if (!run) begin
        ramp_d = '0;
      end else if (wrap) begin
        if (st_q != ST_FWD && st_q != ST_REV) ramp_d = '0;
        else if (ramp_sum > {1'b0, lat_d})    ramp_d = lat_d;
        else                                  ramp_d = ramp_sum[9:0];
      end
    end
    assign eff = (ramp_d < lat_d) ? ramp_d : lat_d;
`else
    assign eff = lat_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q        <= ST_COAST;
        dead_q      <= '0;
        lat_q       <= '0;
        in1_q       <= 1'b0;
        in2_q       <= 1'b0;
        en_q        <= 1'b0;
        dead_flag_q <= 1'b0;
`ifdef SOFT_START_EN
        ramp_q      <= '0;
`endif
      end else begin
        st_q        <= st_d;
        dead_q      <= dead_d;
        lat_q       <= lat_d;
        in1_q       <= (st_d == ST_FWD);
        in2_q       <= (st_d == ST_REV);
        en_q        <= run ? (cnt_d < eff) : (st_d == ST_BRAKE);
        dead_flag_q <= (st_d == ST_DEAD);
`ifdef SOFT_START_EN
        ramp_q      <= ramp_d;
`endif
      end
    end
  end

  assign in1_a  = g_ch[0].in1_q;
  assign in2_a  = g_ch[0].in2_q;
  assign en_a   = g_ch[0].en_q;
  assign dead_a = g_ch[0].dead_flag_q;
  assign in1_b  = g_ch[1].in1_q;
  assign in2_b  = g_ch[1].in2_q;
  assign en_b   = g_ch[1].en_q;
  assign dead_b = g_ch[1].dead_flag_q;
endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Back end of the motion path: takes per-driver direction codes and 3-digit BCD duty factors from the movement logic and drives two H-bridge channels (A, B).
- Each channel gets IN1/IN2 direction pins and an EN pin carrying PWM.
- Duty updates are glitch-free, reversals pass through a dead-time, and a stop command acts fast.
- Sits between the movement logic and the board's motor-driver pins.

Parameters:
- CLK_DIV, 50, system clocks per PWM tick (50 MHz clock → 1 MHz tick → 1 kHz PWM).
- DEAD_PERIODS, 20, PWM periods of coast inserted on a forward↔reverse reversal.
- RAMP_STEP, 10, duty counts added per PWM period in soft-start (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dir_a  in  2  channel A command: 10 forward, 01 reverse, 00 brake, 11 coast
- dir_b  in  2  channel B command, same encoding
- duty_a  in  12  channel A duty, BCD hundreds/tens/units; 999 = max
- duty_b  in  12  channel B duty, BCD
- in1_a  out  1  channel A direction pin 1
- in2_a  out  1  channel A direction pin 2
- en_a  out  1  channel A PWM enable
- in1_b  out  1  channel B direction pin 1
- in2_b  out  1  channel B direction pin 2
- en_b  out  1  channel B PWM enable
- period_start  out  1  one-clock pulse at PWM counter wrap
- dead_a  out  1  channel A in dead-time
- dead_b  out  1  channel B in dead-time

Behaviour:
- Reset (async, rst_n=0): all outputs 0, prescaler=0, period counter=0, both channels COAST, latched duties 0, dead counters 0.
- Input stage: dir_*/duty_* registered once on clk (1-cycle latency, breaks the combinational path from the movement logic).
- Prescaler: counts 0..CLK_DIV-1, asserts tick on CLK_DIV-1.
- Period counter: binary 0..999, advances on tick, wraps 999→0. period_start pulses in the clk where the wrap occurs.
- BCD conversion: each digit >9 is clamped to 9; duty_bin = 100*h + 10*t + u (10 bits, 0..999).
- Latching: duty_bin is latched only at period_start; a mid-period duty change affects the next period only.
- PWM: en = (cnt < duty_lat) in RUN states.
  - Duty 0 → en constantly 0.
  - Duty 999 → en low for exactly 1 tick per period.
- Per-channel FSM states: COAST, FWD, REV, BRAKE, DEAD.
  - COAST: in1=in2=0, en=0.
  - FWD: in1=1, in2=0, en=PWM.
  - REV: in1=0, in2=1, en=PWM.
  - BRAKE: in1=in2=0, en=1 (fast motor stop).
  - DEAD: in1=in2=0, en=0, dead_*=1.
- Brake/coast priority: command 00 (brake) or 11 (coast) from any state takes effect on the clk after the input register (2 clk after the input changes), not waiting for period_start. This aborts DEAD and clears its counter.
- Start: from COAST/BRAKE, command 10/01 enters FWD/REV at the next period_start.
- Reversal: FWD with cmd 01, or REV with cmd 10, enters DEAD at the next period_start.
  - DEAD loads counter = DEAD_PERIODS and decrements at each period_start.
  - At 0, DEAD enters the currently commanded direction; if that is the original direction, the channel still completes the dead-time.
  - DEAD_PERIODS=0 → reversal is direct at period_start, no DEAD state.
- Same-direction command while running: no state change, duty follows the latching rule.
- Channels are fully independent and share only prescaler and period counter.
- Outputs are registered; in1 and in2 are never both 1.
- Reset mid-period: everything returns to reset values immediately; the counter restarts from 0.

Optional Feature:
- Macro SOFT_START_EN.
- Defined: on entering FWD/REV from COAST, BRAKE or DEAD, the effective duty starts at 0 and rises by RAMP_STEP at each period_start until it reaches the latched target, saturating at the target. A lower target applies immediately. Brake/coast resets the ramp to 0.
- Undefined: the latched duty applies from the first period; RAMP_STEP is unused.

Test Plan:
- Reset then dir_a=10, duty_a=12'h500, CLK_DIV=2 → after the next period_start: in1_a=1, in2_a=0, en_a high for 500 ticks (1000 clk) of every 1000-tick period.
- duty_a 12'h999→12'h250 mid-period → current period keeps 999 behaviour; next period en_a is high for 250 ticks.
- duty_a=12'h9A9 (invalid tens digit) → treated as 999. duty_a=0 → en_a stays 0 for the whole period.
- FWD running, dir_a=01, DEAD_PERIODS=3 → at next period_start dead_a=1, in1/in2/en=0 for exactly 3 periods, then in2_a=1 and PWM resumes.
- FWD mid-period, dir_a=00 → 2 clk later in1_a=in2_a=0, en_a=1; channel B unaffected.
- SOFT_START_EN defined, RAMP_STEP=10, start from COAST with duty 12'h050 → effective duty 0, 10, 20, 30, 40, 50, 50… over successive periods.
